day6_seq_divider: RTL

Sequential unsigned restoring divider. It is the inverse arithmetic block of the day5 4-bit multiplier.
- Resolves one quotient bit per clock.
- Uses a start/busy/done handshake.
- Registers the quotient and remainder and holds them until the next accepted start.
- Sits beside the multiplier as the divide datapath unit of the arithmetic series.

---
 rtl/day6_seq_divider_if.sv | 24 ++
 rtl/day6_seq_divider.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/day6_seq_divider_if.sv
// Handshake and operand/result bundle for the day6 sequential divider.
// master: the requester driving start/operands; slave: the divider itself.
interface day6_seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start_in;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] quotient_out;
    logic [WIDTH-1:0] remainder_out;
    logic             div_by_zero_out;

    modport master (
        output start_in, dividend_in, divisor_in,
        input  busy_out, done_out, quotient_out, remainder_out, div_by_zero_out
    );

    modport slave (
        input  start_in, dividend_in, divisor_in,
        output busy_out, done_out, quotient_out, remainder_out, div_by_zero_out
    );
endinterface

// File: rtl/day6_seq_divider.sv
// day6_seq_divider: restoring divider, one quotient bit per clock.
// Optional macro DIV_SIGNED_EN: two's complement operands, magnitudes are
// divided and a one-cycle FIXUP state applies the signs afterwards.
//
// state | meaning
// IDLE  | waiting for start_in; results held
// CALC  | one restoring iteration per clock (single cycle for divide by zero)
// FIXUP | sign correction of quotient/remainder (DIV_SIGNED_EN only)
module day6_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    day6_seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_t;
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dividend;
    logic [CW-1:0]    r_count;
    logic             r_dz;
    logic             r_done;
    logic [WIDTH-1:0] r_quot_out;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_dbz_out;
    logic             w_last;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_dividend_mag;
    logic [WIDTH-1:0] w_divisor_mag;

`ifdef DIV_SIGNED_EN
    logic             r_neg_q;
    logic             r_neg_r;
    assign w_dividend_mag = bus.dividend_in[WIDTH-1] ? -bus.dividend_in : bus.dividend_in;
    assign w_divisor_mag  = bus.divisor_in[WIDTH-1]  ? -bus.divisor_in  : bus.divisor_in;
`else
    assign w_dividend_mag = bus.dividend_in;
    assign w_divisor_mag  = bus.divisor_in;
`endif

    // The shifted-in remainder needs WIDTH+1 bits; its MSB is the borrow.
    assign w_trial    = {r_rem, r_q[WIDTH-1]} - {1'b0, r_divisor};
    assign w_borrow   = w_trial[WIDTH];
    assign w_rem_next = w_borrow ? {r_rem[WIDTH-2:0], r_q[WIDTH-1]} : w_trial[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_last     = (r_state == CALC) && !r_dz && (r_count == LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start_in) w_next_state = CALC;
`ifdef DIV_SIGNED_EN
            CALC:    if (r_dz) w_next_state = IDLE;
                     else if (w_last) w_next_state = FIXUP;
            FIXUP:   w_next_state = IDLE;
`else
            CALC:    if (r_dz || w_last) w_next_state = IDLE;
`endif
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem      <= '0;
            r_q        <= '0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_count    <= '0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
            r_dbz_out  <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_in) begin
                        r_rem      <= '0;
                        r_q        <= w_dividend_mag;
                        r_divisor  <= w_divisor_mag;
                        r_dividend <= bus.dividend_in;
                        r_count    <= '0;
                        r_dz       <= (bus.divisor_in == '0);
                        r_dbz_out  <= 1'b0;
`ifdef DIV_SIGNED_EN
                        r_neg_q    <= bus.dividend_in[WIDTH-1] ^ bus.divisor_in[WIDTH-1];
                        r_neg_r    <= bus.dividend_in[WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    if (r_dz) begin
                        r_quot_out <= '1;
                        r_rem_out  <= r_dividend;
                        r_dbz_out  <= 1'b1;
                        r_done     <= 1'b1;
                    end else begin
                        r_rem   <= w_rem_next;
                        r_q     <= w_q_next;
                        r_count <= r_count + CW'(1);
`ifndef DIV_SIGNED_EN
                        if (w_last) begin
                            r_quot_out <= w_q_next;
                            r_rem_out  <= w_rem_next;
                            r_done     <= 1'b1;
                        end
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                FIXUP: begin
                    r_quot_out <= r_neg_q ? -r_q : r_q;
                    r_rem_out  <= r_neg_r ? -r_rem : r_rem;
                    r_done     <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy_out        = (r_state != IDLE);
    assign bus.done_out        = r_done;
    assign bus.quotient_out    = r_quot_out;
    assign bus.remainder_out   = r_rem_out;
    assign bus.div_by_zero_out = r_dbz_out;
endmodule
